// File: rtl/ksa_pkg.sv
// ksa_pkg: shared helpers for the pipelined Kogge-Stone adder.
// Level count, pipeline register placement and the operation encoding.
package ksa_pkg;

    // Widest operand the prefix network is expected to be built for.
    localparam int KSA_MAX_PRECISION = 1024;

    typedef enum logic {
        KSA_ADD = 1'b0,
        KSA_SUB = 1'b1
    } ksa_op_e;

    // Number of prefix levels needed to cover a PRECISION-wide carry chain.
    function automatic int ksa_levels(input int width);
        return $clog2(width);
    endfunction

    // Prefix level after which pipeline register `stage` captures the network.
    function automatic int ksa_split_level(input int stage, input int stages, input int levels);
        return (stage * levels) / stages;
    endfunction

endpackage

// File: rtl/ksa_prefix_level.sv
// ksa_prefix_level: one combinational Kogge-Stone prefix level.
// Each position combines itself with the position SPAN below it; positions
// below SPAN already hold their final group terms and pass straight through.
module ksa_prefix_level #(
    parameter int PRECISION = 32,
    parameter int SPAN      = 1
) (
    input  logic [PRECISION-1:0] g_i,
    input  logic [PRECISION-1:0] p_i,
    output logic [PRECISION-1:0] g_o,
    output logic [PRECISION-1:0] p_o
);

    // Group generate/propagate merge: (g,p)[i] o (g,p)[i-SPAN]
    always_comb begin
        g_o = g_i;
        p_o = p_i;
        for (int i = SPAN; i < PRECISION; i++) begin
            g_o[i] = g_i[i] | (p_i[i] & g_i[i - SPAN]);
            p_o[i] = p_i[i] & p_i[i - SPAN];
        end
    end

endmodule

// File: rtl/pipelined_kogge_stone_adder.sv
// pipelined_kogge_stone_adder: A+B+cin / A-B-borrow through a pipelined
// Kogge-Stone prefix network with valid/ready flow control.
// Network position 0 carries the carry-in, so position i holds the carry into
// sum bit i once all levels are applied; carry out is formed from bit MSB.
// Optional build macro KSA_STATUS_FLAGS_EN adds zero_o and negative_o.
module pipelined_kogge_stone_adder
    import ksa_pkg::*;
#(
    parameter int PRECISION   = 32,
    parameter int PIPE_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [PRECISION-1:0] operand_a_i,
    input  logic [PRECISION-1:0] operand_b_i,
    input  logic                 op_sub_i,
    input  logic                 carry_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [PRECISION-1:0] result_o,
    output logic                 carry_o,
    output logic                 overflow_o
`ifdef KSA_STATUS_FLAGS_EN
    ,
    output logic                 zero_o,
    output logic                 negative_o
`endif
);

    localparam int LEVELS = ksa_levels(PRECISION);
    localparam int MSB    = PRECISION - 1;

    ksa_op_e                op;
    logic [MSB:0]           b_x;
    logic                   cin;

    // Network state entering each stage; index 0 is the conditioned input.
    logic [MSB:0]           g_s     [0:PIPE_STAGES-1];
    logic [MSB:0]           p_s     [0:PIPE_STAGES-1];
    logic [MSB:0]           pb_s    [0:PIPE_STAGES-1];
    logic                   a_msb_s [0:PIPE_STAGES-1];
    logic                   b_msb_s [0:PIPE_STAGES-1];

    logic [PIPE_STAGES:1]   vld;
    logic [PIPE_STAGES:1]   rdy;

    assign op = ksa_op_e'(op_sub_i);

    // Subtraction is folded into addition: A + ~B + ~borrow
    always_comb begin
        b_x = (op == KSA_SUB) ? ~operand_b_i : operand_b_i;
        cin = (op == KSA_SUB) ? ~carry_i : carry_i;
    end

    assign g_s[0]     = {operand_a_i[MSB-1:0] & b_x[MSB-1:0], cin};
    assign p_s[0]     = {operand_a_i[MSB-1:0] ^ b_x[MSB-1:0], 1'b0};
    assign pb_s[0]    = operand_a_i ^ b_x;
    assign a_msb_s[0] = operand_a_i[MSB];
    assign b_msb_s[0] = b_x[MSB];

    // Ready ripples backward: a stage advances when empty or its successor advances
    always_comb begin
        logic r;
        r = out_ready_i;
        for (int j = PIPE_STAGES; j >= 1; j--) begin
            rdy[j] = !vld[j] || r;
            r      = rdy[j];
        end
    end

    assign in_ready_o  = rdy[1];
    assign out_valid_o = vld[PIPE_STAGES];

    for (genvar j = 1; j <= PIPE_STAGES; j++) begin : g_stage
        localparam int LO = ksa_split_level(j - 1, PIPE_STAGES, LEVELS);
        localparam int HI = ksa_split_level(j, PIPE_STAGES, LEVELS);

        logic up_vld;
        logic load;
        logic vld_d;
        logic vld_q;

        if (j == 1) begin : g_src_in
            assign up_vld = in_valid_i;
        end else begin : g_src_stage
            assign up_vld = vld[j-1];
        end

        // Prefix levels evaluated between the previous register and this one
        for (genvar k = LO; k < HI; k++) begin : g_level
            logic [MSB:0] g_in;
            logic [MSB:0] p_in;
            logic [MSB:0] g_out;
            logic [MSB:0] p_out;

            if (k == LO) begin : g_first
                assign g_in = g_s[j-1];
                assign p_in = p_s[j-1];
            end else begin : g_next
                assign g_in = g_level[k-1].g_out;
                assign p_in = g_level[k-1].p_out;
            end

            ksa_prefix_level #(
                .PRECISION (PRECISION),
                .SPAN      (1 << k)
            ) u_level (
                .g_i (g_in),
                .p_i (p_in),
                .g_o (g_out),
                .p_o (p_out)
            );
        end

        assign load   = rdy[j] && up_vld;
        assign vld[j] = vld_q;

        // Occupancy refills from upstream when the stage advances, else holds
        always_comb vld_d = rdy[j] ? up_vld : vld_q;

        // Stage occupancy flop
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) vld_q <= 1'b0;
            else       vld_q <= vld_d;
        end

        if (j < PIPE_STAGES) begin : g_mid
            logic [MSB:0] g_d,  g_q;
            logic [MSB:0] p_d,  p_q;
            logic [MSB:0] pb_d, pb_q;
            logic         am_d, am_q;
            logic         bm_d, bm_q;

            // Capture the partial prefix state only when a valid item moves in
            always_comb begin
                g_d  = g_q;
                p_d  = p_q;
                pb_d = pb_q;
                am_d = am_q;
                bm_d = bm_q;
                if (load) begin
                    g_d  = g_level[HI-1].g_out;
                    p_d  = g_level[HI-1].p_out;
                    pb_d = pb_s[j-1];
                    am_d = a_msb_s[j-1];
                    bm_d = b_msb_s[j-1];
                end
            end

            // Intermediate pipeline register
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    g_q  <= '0;
                    p_q  <= '0;
                    pb_q <= '0;
                    am_q <= 1'b0;
                    bm_q <= 1'b0;
                end else begin
                    g_q  <= g_d;
                    p_q  <= p_d;
                    pb_q <= pb_d;
                    am_q <= am_d;
                    bm_q <= bm_d;
                end
            end

            assign g_s[j]     = g_q;
            assign p_s[j]     = p_q;
            assign pb_s[j]    = pb_q;
            assign a_msb_s[j] = am_q;
            assign b_msb_s[j] = bm_q;
        end else begin : g_last
            logic [MSB:0] carries;
            logic [MSB:0] sum;
            logic         co;
            logic         ov;
            logic         unused_p;
            logic [MSB:0] res_d, res_q;
            logic         co_d,  co_q;
            logic         ov_d,  ov_q;

            // The final group-propagate vector has no consumer.
            assign unused_p = ^g_level[HI-1].p_out;
            assign carries  = g_level[HI-1].g_out;
            assign sum      = pb_s[j-1] ^ carries;
            assign co       = (a_msb_s[j-1] & b_msb_s[j-1]) | (pb_s[j-1][MSB] & carries[MSB]);
            assign ov       = (a_msb_s[j-1] == b_msb_s[j-1]) && (sum[MSB] != a_msb_s[j-1]);

            // Result registers update only on an incoming valid item; held under stall
            always_comb begin
                res_d = res_q;
                co_d  = co_q;
                ov_d  = ov_q;
                if (load) begin
                    res_d = sum;
                    co_d  = co;
                    ov_d  = ov;
                end
            end

            // Output register
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    res_q <= '0;
                    co_q  <= 1'b0;
                    ov_q  <= 1'b0;
                end else begin
                    res_q <= res_d;
                    co_q  <= co_d;
                    ov_q  <= ov_d;
                end
            end

            assign result_o   = res_q;
            assign carry_o    = co_q;
            assign overflow_o = ov_q;

`ifdef KSA_STATUS_FLAGS_EN
            logic zero_d, zero_q;
            logic neg_d,  neg_q;

            // Status flags travel with the result
            always_comb begin
                zero_d = zero_q;
                neg_d  = neg_q;
                if (load) begin
                    zero_d = (sum == '0);
                    neg_d  = sum[MSB];
                end
            end

            // Status flag register
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    zero_q <= 1'b0;
                    neg_q  <= 1'b0;
                end else begin
                    zero_q <= zero_d;
                    neg_q  <= neg_d;
                end
            end

            assign zero_o     = zero_q;
            assign negative_o = neg_q;
`endif
        end
    end

endmodule

// File: tb/tb_pipelined_kogge_stone_adder.sv
// tb_pipelined_kogge_stone_adder: directed and randomized checks of the
// pipelined adder against an arithmetic reference kept in the bench.
`timescale 1ns/1ps
module tb_pipelined_kogge_stone_adder;

    localparam int P     = 32;
    localparam int S     = 2;
    localparam int NRAND = 10000;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [P-1:0] operand_a_i;
    logic [P-1:0] operand_b_i;
    logic         op_sub_i;
    logic         carry_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [P-1:0] result_o;
    logic         carry_o;
    logic         overflow_o;
`ifdef KSA_STATUS_FLAGS_EN
    logic         zero_o;
    logic         negative_o;
`endif

    typedef struct packed {
        logic [P+1:0] exp;
        logic         lit_en;
        logic [P+1:0] lit;
        logic         lat_en;
        int           acc;
    } item_t;

    item_t        q[$];
    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    int           pops = 0;
    logic         cur_lit_en = 1'b0;
    logic [P+1:0] cur_lit = '0;
    logic         cur_lat_en = 1'b0;
    logic         held_v = 1'b0;
    logic [P+1:0] held = '0;

    always #5 clk = ~clk;

    pipelined_kogge_stone_adder #(
        .PRECISION   (P),
        .PIPE_STAGES (S)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .operand_a_i (operand_a_i),
        .operand_b_i (operand_b_i),
        .op_sub_i    (op_sub_i),
        .carry_i     (carry_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .carry_o     (carry_o),
        .overflow_o  (overflow_o)
`ifdef KSA_STATUS_FLAGS_EN
        ,
        .zero_o      (zero_o),
        .negative_o  (negative_o)
`endif
    );

    // Reference: returns {overflow, carry, result} from plain integer arithmetic.
    function automatic logic [P+1:0] model(input logic [P-1:0] a, input logic [P-1:0] b,
                                           input logic sub, input logic c);
        logic [P+1:0]        ua, ub, uc, ur;
        logic signed [P+1:0] sa, sb, sc, sr, smax, smin;
        logic                carry, ovf;
        ua = {2'b00, a};
        ub = {2'b00, b};
        uc = '0;
        uc[0] = c;
        sa = {{2{a[P-1]}}, a};
        sb = {{2{b[P-1]}}, b};
        sc = '0;
        sc[0] = c;
        smax = '0;
        smax[P-2:0] = '1;
        smin = '1;
        smin[P-2:0] = '0;
        if (!sub) begin
            ur    = ua + ub + uc;
            carry = (ur >= (({{(P+1){1'b0}}, 1'b1}) << P));
            sr    = sa + sb + sc;
        end else begin
            ur    = ua - ub - uc;
            carry = (ua >= ub + uc);
            sr    = sa - sb - sc;
        end
        ovf = (sr > smax) || (sr < smin);
        return {ovf, carry, ur[P-1:0]};
    endfunction

    function automatic logic [P-1:0] rand_operand();
        logic [P-1:0] r;
        r = '0;
        case ($urandom_range(7))
            0: r = '0;
            1: r = '1;
            2: r[P-1] = 1'b1;
            3: begin r = '1; r[P-1] = 1'b0; end
            default: for (int i = 0; i < P; i++) r[i] = 1'($urandom_range(1));
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: one compare process, sampled on the falling edge
    always @(negedge clk) begin
        item_t        it;
        logic [P+1:0] got;
        cyc++;
        got = {overflow_o, carry_o, result_o};
        if (rst_i) begin
            q.delete();
            held_v = 1'b0;
`ifdef KSA_STATUS_FLAGS_EN
            chk("reset_outputs", {zero_o, negative_o, out_valid_o, got}, '0);
`else
            chk("reset_outputs", {out_valid_o, got}, '0);
`endif
        end else begin
            if (held_v) chk("stall_hold", {out_valid_o, got}, {1'b1, held});
            held_v = out_valid_o && !out_ready_i;
            held   = got;
            if (out_valid_o && out_ready_i) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL stale_output: got result %0h with nothing outstanding", result_o);
                end else begin
                    it = q.pop_front();
                    pops++;
                    chk("model", got, it.exp);
                    if (it.lit_en) chk("literal", got, it.lit);
                    if (it.lat_en) chk("latency", cyc - it.acc, S);
`ifdef KSA_STATUS_FLAGS_EN
                    chk("status_flags", {zero_o, negative_o}, {(it.exp[P-1:0] == '0), it.exp[P-1]});
`endif
                end
            end
            if (in_valid_i && in_ready_o) begin
                it.exp    = model(operand_a_i, operand_b_i, op_sub_i, carry_i);
                it.lit_en = cur_lit_en;
                it.lit    = cur_lit;
                it.lat_en = cur_lat_en;
                it.acc    = cyc;
                q.push_back(it);
            end
        end
    end

    task automatic send(input logic [P-1:0] a, input logic [P-1:0] b,
                        input logic sub, input logic c, input logic [P+1:0] lit);
        int n;
        @(posedge clk); #1;
        in_valid_i  = 1'b1;
        operand_a_i = a;
        operand_b_i = b;
        op_sub_i    = sub;
        carry_i     = c;
        cur_lit_en  = 1'b1;
        cur_lit     = lit;
        cur_lat_en  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready_o) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready_o=%0b required 1", in_ready_o);
        end
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        cur_lit_en = 1'b0;
        cur_lat_en = 1'b0;
        repeat (S + 2) @(posedge clk);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((q.size() != 0 || out_valid_o) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(name, q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int   k, t, n, p0;
        logic acc, saw_block;

        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        op_sub_i    = 1'b0;
        carry_i     = 1'b0;
        operand_a_i = '0;
        operand_b_i = '0;

        // Hand-computed expectations pinning the reference
        chk("pin_add_wrap",  model(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0), {2'b01, 32'h00000000});
        chk("pin_add_ovf",   model(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0), {2'b10, 32'h80000000});
        chk("pin_sub_ovf",   model(32'h80000000, 32'h1, 1'b1, 1'b0), {2'b11, 32'h7FFFFFFF});
        chk("pin_sub_brw",   model(32'h5, 32'h3, 1'b1, 1'b1),        {2'b01, 32'h00000001});
        chk("pin_sub_neg",   model(32'h3, 32'h5, 1'b1, 1'b0),        {2'b00, 32'hFFFFFFFE});

        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", in_ready_o, 1);
        chk("valid_after_reset", out_valid_o, 0);

        // Directed arithmetic corners, each with latency pinned
        send(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, {2'b01, 32'h00000000});
        send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, {2'b10, 32'h80000000});
        send(32'h80000000, 32'h00000001, 1'b1, 1'b0, {2'b11, 32'h7FFFFFFF});
        send(32'h00000005, 32'h00000003, 1'b1, 1'b1, {2'b01, 32'h00000001});
        send(32'h00000003, 32'h00000005, 1'b1, 1'b0, {2'b00, 32'hFFFFFFFE});
        send(32'h00000000, 32'h00000000, 1'b0, 1'b1, {2'b00, 32'h00000001});
        send(32'h00000000, 32'h80000000, 1'b1, 1'b0, {2'b10, 32'h80000000});

        // Reset with two operations in flight; none may emerge afterwards
        out_ready_i = 1'b0;
        @(posedge clk); #1;
        in_valid_i  = 1'b1;
        operand_a_i = 32'h12345678;
        operand_b_i = 32'h11111111;
        op_sub_i    = 1'b0;
        carry_i     = 1'b0;
        @(posedge clk); #1;
        operand_a_i = 32'hCAFEF00D;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        #2 rst_i = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
        out_ready_i = 1'b1;
        @(negedge clk);
        chk("ready_after_midreset", in_ready_o, 1);
        chk("valid_after_midreset", out_valid_o, 0);
        repeat (8) @(posedge clk);

        // Back-to-back stream with output stalled for cycles 3..6
        k = 0;
        t = 0;
        acc = 1'b1;
        saw_block = 1'b0;
        p0 = pops;
        while (k < 8 && t < 50) begin
            @(posedge clk); #1;
            out_ready_i = !(t >= 3 && t <= 6);
            in_valid_i  = 1'b1;
            if (acc) begin
                operand_a_i = rand_operand();
                operand_b_i = rand_operand();
                op_sub_i    = 1'($urandom_range(1));
                carry_i     = 1'($urandom_range(1));
            end
            @(negedge clk);
            if (!out_ready_i && !in_ready_o) saw_block = 1'b1;
            acc = in_ready_o;
            if (in_ready_o) k++;
            t++;
        end
        @(posedge clk); #1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        drain("bp_drain");
        chk("bp_ready_dropped", saw_block, 1);
        chk("bp_delivered", pops - p0, 8);

        // Randomized traffic with random backpressure
        k = 0;
        n = 0;
        acc = 1'b1;
        p0 = pops;
        while (k < NRAND && n < 60000) begin
            @(posedge clk); #1;
            out_ready_i = ($urandom_range(3) != 0);
            if (acc) begin
                in_valid_i  = ($urandom_range(3) != 0);
                operand_a_i = rand_operand();
                operand_b_i = rand_operand();
                op_sub_i    = 1'($urandom_range(1));
                carry_i     = 1'($urandom_range(1));
            end
            @(negedge clk);
            acc = !in_valid_i || in_ready_o;
            if (in_valid_i && in_ready_o) k++;
            n++;
        end
        @(posedge clk); #1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        drain("rand_drain");
        chk("rand_accepted", k, NRAND);
        chk("rand_delivered", pops - p0, NRAND);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipelined_kogge_stone_adder.md
Name: pipelined_kogge_stone_adder

Overview:
- Parametrised, pipelined successor to the team's combinational Kogge-Stone adder.
- Computes A+B+cin or A-B-borrow through a log2(PRECISION)-level parallel-prefix carry network.
- Register stages are distributed across the prefix levels, with a valid/ready handshake and full backpressure.
- Sits in the datapath wherever a wide add must close timing at high clock rates; sustains one operation per cycle.

Parameters:
- PRECISION, 32, operand/result width in bits; must be >= 2; non-power-of-two allowed.
- PIPE_STAGES, 2, number of register stages and therefore latency in cycles; legal range 1..LEVELS, where LEVELS = $clog2(PRECISION).

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous active-high reset
- in_valid_i  in  1  operands presented
- in_ready_o  out  1  adder accepts operands this cycle
- operand_a_i  in  PRECISION  operand A
- operand_b_i  in  PRECISION  operand B
- op_sub_i  in  1  0 = add, 1 = subtract (A - B)
- carry_i  in  1  carry-in when adding; borrow-in when subtracting
- out_valid_o  out  1  result valid
- out_ready_i  in  1  downstream accepts result
- result_o  out  PRECISION  sum/difference, mod 2^PRECISION
- carry_o  out  1  raw carry out of bit PRECISION-1 (unsigned overflow; in subtract mode 1 = no borrow)
- overflow_o  out  1  two's-complement signed overflow

Behaviour:
- Reset is asynchronous and active-high. While rst_i=1, every stage valid clears and every data register resets to 0.
  - Outputs at reset: out_valid_o=0, result_o=0, carry_o=0, overflow_o=0.
  - in_ready_o=1 after reset.
- Arithmetic:
  - B' = op_sub_i ? ~operand_b_i : operand_b_i.
  - cin = op_sub_i ? ~carry_i : carry_i.
  - {carry_o, result_o} = A + B' + cin, computed at PRECISION+1 bits.
  - overflow_o = (A[MSB] == B'[MSB]) && (result_o[MSB] != A[MSB]).
- Datapath:
  - Pre-process g = A&B', p = A^B', with cin injected as g[-1].
  - LEVELS Kogge-Stone prefix levels, span 2^k at level k.
  - Final sum = p ^ {carries}.
- Register placement: stage j (1..PIPE_STAGES) registers the network state after prefix level floor(j*LEVELS/PIPE_STAGES). The last stage holds the final result and flags. Each register carries the G/P vectors plus the p vector, B'[MSB] and A[MSB] needed downstream.
- Latency: an accepted input appears on out_valid_o exactly PIPE_STAGES cycles later, provided there is no backpressure.
- Handshake:
  - Transfer occurs on valid&&ready at the rising edge.
  - Stage j advances when !valid_j || ready_{j+1}, with ready_{PIPE_STAGES+1} = out_ready_i.
  - in_ready_o = stage-1 advance condition. It is combinational from out_ready_i through the chain; no skid buffer.
- Boundary conditions:
  - Full pipeline with out_ready_i=1 and in_valid_i=1: input accepted and output retired in the same cycle; throughput 1/cycle.
  - Full pipeline with out_ready_i=0: in_ready_o=0; all stages and output data hold stable.
  - Bubbles collapse: an empty stage accepts data even when downstream is stalled.
  - out_valid_o=1 with out_ready_i=0: result_o/carry_o/overflow_o must not change until the transfer.
  - Operand inputs are ignored when in_valid_i=0 or in_ready_o=0.
  - Reset mid-operation: all in-flight operations are discarded and none emerge after reset release.
  - Wrap-around: results are modulo 2^PRECISION; carry_o reports the lost bit.

Optional Feature:
- Macro KSA_STATUS_FLAGS_EN.
- Defined: adds ports zero_o (out, 1, result_o==0) and negative_o (out, 1, result_o[MSB]). Both are registered with the final stage, reset to 0, valid with out_valid_o, and held under stall.
- Undefined: the ports do not exist and no extra logic is generated.

Decomposition:
- Package ksa_pkg:
  - function ksa_levels(width) returning $clog2.
  - function ksa_split_level(stage, stages, levels) returning the register boundary level.
  - localparam for maximum PRECISION.
  - typedef enum {KSA_ADD, KSA_SUB} for op.
- Sub-module ksa_prefix_level: combinational single prefix level, parameters PRECISION and SPAN, maps G/P in to G/P out. Instantiated LEVELS times via generate.

Test Plan:
- Reset: assert rst_i mid-stream with 2 ops in flight, release -> out_valid_o=0, outputs 0, no stale result ever appears.
- Add wrap: A=0xFFFFFFFF, B=0x00000001, carry_i=0, add -> result 0x00000000, carry_o=1, overflow_o=0, exactly 2 cycles after accept.
- Signed overflow: A=0x7FFFFFFF, B=0x00000001 add -> 0x80000000, carry_o=0, overflow_o=1. Subtract A=0x80000000, B=0x00000001, carry_i=0 -> 0x7FFFFFFF, carry_o=1, overflow_o=1.
- Borrow-in: subtract A=5, B=3, carry_i=1 -> result 1, carry_o=1. Subtract A=3, B=5, carry_i=0 -> 0xFFFFFFFE, carry_o=0.
- Backpressure: stream 8 ops back-to-back, out_ready_i=0 for cycles 3-6 -> in_ready_o drops once full, held output stable, all 8 results delivered in order with no loss or duplication.
- Random: 10000 random ops with random op_sub_i/carry_i and random out_ready_i over PRECISION in {8,32,37,64} and PIPE_STAGES in {1,LEVELS} -> every result matches the behavioural reference.
